// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory / MMIO responder.
// Contents: MMIO register word indices, timer CTRL/STATUS bit positions,
// timer state enum, address-region enum, request payload struct and the
// region decode helper.
package dmem_pkg;

  // MMIO register word index = byte offset[7:2] within the 256-byte page
  localparam logic [5:0] MMIO_LED    = 6'h00;  // 0x00
  localparam logic [5:0] MMIO_SW     = 6'h01;  // 0x04
  localparam logic [5:0] MMIO_CYCLE  = 6'h02;  // 0x08
  localparam logic [5:0] MMIO_LOAD   = 6'h03;  // 0x0C
  localparam logic [5:0] MMIO_CTRL   = 6'h04;  // 0x10
  localparam logic [5:0] MMIO_STATUS = 6'h05;  // 0x14
  localparam logic [5:0] MMIO_COUNT  = 6'h06;  // 0x18

  // Timer control / status bit positions
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_W      = 3;
  localparam int unsigned STATUS_EXP  = 0;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUN  = 2'd1,
    TMR_DONE = 2'd2
  } timer_state_e;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_MMIO = 2'd1,
    RGN_NONE = 2'd2
  } region_e;

  // Datapath-side request as seen by the responder
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
  } dmem_req_t;

  // RAM occupies the bottom ram_bytes; MMIO is the 256-byte page at mmio_base
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [31:0] mmio_base);
    region_e r;
    if (addr < ram_bytes)                   r = RGN_RAM;
    else if (addr[31:8] == mmio_base[31:8]) r = RGN_MMIO;
    else                                    r = RGN_NONE;
    return r;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_timer.sv
// mmio_timer: down-counting MMIO timer with one-shot / auto-reload modes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load_we/ctrl_we/status_we  register write strobes (already decoded)
//   wdata                 store data
//   load, ctrl, exp, count  register read-back
//   irq                   level interrupt, registered from exp & IRQ_EN
module mmio_timer
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_we,
  input  logic              ctrl_we,
  input  logic              status_we,
  input  logic [31:0]       wdata,
  output logic [31:0]       load,
  output logic [CTRL_W-1:0] ctrl,
  output logic              exp,
  output logic [31:0]       count,
  output logic              irq
);

  timer_state_e state;
  logic         auto_sel;

  // A CTRL write that keeps EN=1 while running takes effect on the same expiry
  assign auto_sel = ctrl_we ? wdata[CTRL_AUTO] : ctrl[CTRL_AUTO];

  // Timer registers and FSM; later assignments to exp win, so an expiry beats a W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TMR_IDLE;
      load  <= '0;
      ctrl  <= '0;
      exp   <= 1'b0;
      count <= '0;
      irq   <= 1'b0;
    end else begin
      irq <= exp & ctrl[CTRL_IRQ_EN];
      if (load_we) load <= wdata;
      if (status_we && wdata[STATUS_EXP]) exp <= 1'b0;
      if (ctrl_we) ctrl <= wdata[CTRL_W-1:0];

      if (ctrl_we && !wdata[CTRL_EN]) begin
        state <= TMR_IDLE;
      end else if (ctrl_we && state != TMR_RUN) begin
        state <= TMR_RUN;
        count <= load;
      end else if (state == TMR_RUN) begin
        if (count != '0) begin
          count <= count - 32'd1;
        end else begin
          exp <= 1'b1;
          if (auto_sel) begin
            count <= load;
          end else begin
            state         <= TMR_DONE;
            ctrl[CTRL_EN] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-port responder for a single-cycle datapath.
// Word RAM at 0 .. DEPTH*4-1 plus a 256-byte MMIO page at MMIO_BASE with
// LED, synchronized switches, free-running cycle counter and, when the
// macro DMEM_TIMER_EN is defined, a down-counting timer with interrupt.
// Ports:
//   Clock    rising-edge clock        Reset   async active-low reset
//   addr     byte address             wdata   store data
//   wmem     write strobe             rdata   combinational load data
//   sw_in    async switch inputs      led_out LED register
//   irq      timer interrupt (0 when DMEM_TIMER_EN is undefined)
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        irq
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  dmem_req_t      req;
  region_e        region;
  logic [AW-1:0]  ram_idx;
  logic [5:0]     reg_sel;
  logic           mmio_we;

  logic [31:0]                      mem [DEPTH];
  logic [SYNC_STAGES-1:0][15:0]     sync_q;
  logic [31:0]                      cycle;

  assign req     = {addr, wdata, wmem};
  assign region  = decode_region(req.addr, RAM_BYTES, MMIO_BASE);
  assign ram_idx = req.addr[AW+1:2];
  assign reg_sel = req.addr[7:2];
  assign mmio_we = req.wmem && (region == RGN_MMIO);

  // Word RAM, not reset
  always_ff @(posedge Clock) begin
    if (req.wmem && region == RGN_RAM) mem[ram_idx] <= req.wdata;
  end

  // LED, switch synchronizer (stage 0 newest) and cycle counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      led_out <= '0;
      sync_q  <= '0;
      cycle   <= '0;
    end else begin
      if (mmio_we && reg_sel == MMIO_LED) led_out <= req.wdata[15:0];
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
      cycle  <= cycle + 32'd1;
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0]       tmr_load;
  logic [31:0]       tmr_count;
  logic [CTRL_W-1:0] tmr_ctrl;
  logic              tmr_exp;

  mmio_timer u_timer (
    .clk       (Clock),
    .rst_n     (Reset),
    .load_we   (mmio_we && reg_sel == MMIO_LOAD),
    .ctrl_we   (mmio_we && reg_sel == MMIO_CTRL),
    .status_we (mmio_we && reg_sel == MMIO_STATUS),
    .wdata     (req.wdata),
    .load      (tmr_load),
    .ctrl      (tmr_ctrl),
    .exp       (tmr_exp),
    .count     (tmr_count),
    .irq       (irq)
  );
`else
  assign irq = 1'b0;
`endif

  // Read mux: reflects state before any same-cycle write commits
  always_comb begin
    rdata = '0;
    case (region)
      RGN_RAM: rdata = mem[ram_idx];
      RGN_MMIO: begin
        case (reg_sel)
          MMIO_LED:    rdata = {16'h0, led_out};
          MMIO_SW:     rdata = {16'h0, sync_q[SYNC_STAGES-1]};
          MMIO_CYCLE:  rdata = cycle;
`ifdef DMEM_TIMER_EN
          MMIO_LOAD:   rdata = tmr_load;
          MMIO_CTRL:   rdata = 32'(tmr_ctrl);
          MMIO_STATUS: rdata = 32'(tmr_exp);
          MMIO_COUNT:  rdata = tmr_count;
`endif
          default:     rdata = '0;
        endcase
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: the stimulus side pushes expected
// values into queues, a negedge monitor pops and compares them.
module tb_dmem_mmio_responder;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [31:0] MB        = 32'hFFFF_FF00;
  localparam logic [31:0] A_LED     = MB;
  localparam logic [31:0] A_SW      = MB + 32'h04;
  localparam logic [31:0] A_CYC     = MB + 32'h08;
  localparam logic [31:0] A_LOAD    = MB + 32'h0C;
  localparam logic [31:0] A_CTRL    = MB + 32'h10;
  localparam logic [31:0] A_STAT    = MB + 32'h14;
  localparam logic [31:0] A_CNT     = MB + 32'h18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr, wdata, rdata;
  logic        wmem;
  logic [15:0] sw_in, led_out;
  logic        irq;

  dmem_mmio_responder dut (
    .Clock   (clk),
    .Reset   (rst_n),
    .addr    (addr),
    .wdata   (wdata),
    .wmem    (wmem),
    .rdata   (rdata),
    .sw_in   (sw_in),
    .led_out (led_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // scoreboard: kind 0 = rdata, 1 = led_out, 2 = irq
  logic [31:0] exp_q [$];
  int          kind_q [$];
  string       name_q [$];
  int          n_chk = 0;
  int          n_pass = 0;

  // reference state
  logic [31:0] ram_ref [DEPTH];
  bit          ram_ok [DEPTH];
  logic [15:0] led_ref = '0;
  logic [15:0] sw_next = '0;
  logic [15:0] sw_hist [$];
  logic [31:0] cyc_ref = '0;

  // cycles elapsed since reset release
  always @(posedge clk) if (rst_n) cyc_ref <= cyc_ref + 32'd1;
  always @(negedge rst_n) cyc_ref <= '0;

  task automatic expect_val(input int k, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    kind_q.push_back(k);
    name_q.push_back(nm);
  endtask

  // one bus cycle; optional rdata expectation for this cycle
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input bit chk, input logic [31:0] e, input string nm);
    @(posedge clk); #1;
    addr  = a;
    wdata = d;
    wmem  = w;
    sw_in = sw_next;
    sw_hist.push_back(sw_next);
    if (chk) expect_val(0, e, nm);
  endtask

  function automatic int pick_idx();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return DEPTH - 1;
    return int'($urandom_range(0, 15));
  endfunction

  logic [31:0] mon_e, mon_g;
  int          mon_k;
  string       mon_n;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_k = kind_q.pop_front();
      mon_n = name_q.pop_front();
      case (mon_k)
        0:       mon_g = rdata;
        1:       mon_g = {16'h0, led_out};
        default: mon_g = {31'h0, irq};
      endcase
      n_chk++;
      if (mon_g === mon_e) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", mon_n, mon_g, mon_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, e;
    logic [15:0] led_cur;
    int          op, idx;

    addr = '0; wdata = '0; wmem = 1'b0; sw_in = '0;
    #1 rst_n = 1'b0;
    #1 addr = A_CYC;
    expect_val(0, 32'h0, "rst_cycle");
    expect_val(1, 32'h0, "rst_led");
    expect_val(2, 32'h0, "rst_irq");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(A_CYC, 0, 1'b0, 1'b1, 32'd1, "cycle_first");
    cyc(A_CYC, 0, 1'b0, 1'b1, 32'd2, "cycle_second");

    // RAM and decode
    cyc(32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 0, "");
    ram_ref[0] = 32'hCAFE_F00D; ram_ok[0] = 1'b1;
    cyc(32'h10, 32'h1111_1111, 1'b1, 1'b0, 0, "");
    cyc(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1111_1111, "ram_same_cycle_old");
    ram_ref[4] = 32'hDEAD_BEEF; ram_ok[4] = 1'b1;
    cyc(32'h13, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, "ram_rd_unaligned");
    cyc(RAM_BYTES, 32'h1234, 1'b1, 1'b1, 32'h0, "unmapped_wr");
    cyc(RAM_BYTES, 0, 1'b0, 1'b1, 32'h0, "unmapped_rd");
    cyc(32'h0, 0, 1'b0, 1'b1, 32'hCAFE_F00D, "no_alias");
    cyc(A_LED, 32'h0001_A5A5, 1'b1, 1'b1, 32'h0, "led_old");
    cyc(A_LED, 0, 1'b0, 1'b1, 32'h0000_A5A5, "led_rd");
    expect_val(1, 32'h0000_A5A5, "led_out");
    led_ref = 16'hA5A5;

    // switch synchronizer latency
    sw_next = 16'h0000;
    repeat (3) cyc(A_SW, 0, 1'b0, 1'b1, 32'h0, "sw_zero");
    sw_next = 16'h00FF;
    cyc(A_SW, 0, 1'b0, 1'b1, 32'h0, "sw_edge0");
    cyc(A_SW, 0, 1'b0, 1'b1, 32'h0, "sw_edge1");
    cyc(A_SW, 0, 1'b0, 1'b1, 32'h0000_00FF, "sw_edge2");

    // randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      op      = int'($urandom_range(0, 7));
      d       = $urandom;
      led_cur = led_ref;
      sw_next = 16'($urandom);
      case (op)
        0: begin
          idx = pick_idx();
          a = 32'(idx) * 32'd4 + 32'($urandom_range(0, 3));
          cyc(a, d, 1'b1, ram_ok[idx], ram_ref[idx], "rnd_ram_wr_old");
          ram_ref[idx] = d; ram_ok[idx] = 1'b1;
        end
        1, 2: begin
          idx = pick_idx();
          a = 32'(idx) * 32'd4 + 32'($urandom_range(0, 3));
          cyc(a, d, 1'b0, ram_ok[idx], ram_ref[idx], "rnd_ram_rd");
        end
        3: begin
          cyc(A_LED, d, 1'b1, 1'b1, {16'h0, led_ref}, "rnd_led_wr_old");
          led_ref = d[15:0];
        end
        4: cyc(A_LED, d, 1'b0, 1'b1, {16'h0, led_ref}, "rnd_led_rd");
        5: begin
          e = {16'h0, sw_hist[sw_hist.size() - 2]};
          cyc(A_SW, d, 1'b0, 1'b1, e, "rnd_sw");
        end
        6: begin
          cyc(A_CYC, d, 1'b0, 1'b0, 0, "");
          expect_val(0, cyc_ref, "rnd_cycle");
        end
        default: begin
          case ($urandom_range(0, 2))
            0: a = RAM_BYTES + 32'($urandom_range(0, 1000)) * 32'd4;
            1: a = MB + 32'($urandom_range(7, 63)) * 32'd4;
            default: a = 32'h8000_0000 + 32'($urandom_range(0, 65535));
          endcase
          cyc(a, d, 1'b1, 1'b1, 32'h0, "rnd_unmapped");
        end
      endcase
      expect_val(1, {16'h0, led_cur}, "rnd_led_out");
      expect_val(2, 32'h0, "rnd_irq");
    end
    sw_next = sw_in;

`ifdef DMEM_TIMER_EN
    // one-shot
    cyc(A_LOAD, 32'd3, 1'b1, 1'b0, 0, "");
    cyc(A_CTRL, 32'h5, 1'b1, 1'b1, 32'h0, "ctrl_idle");
    cyc(A_CNT, 0, 1'b0, 1'b1, 32'd3, "count3");
    cyc(A_CNT, 0, 1'b0, 1'b1, 32'd2, "count2");
    cyc(A_CNT, 0, 1'b0, 1'b1, 32'd1, "count1");
    cyc(A_CNT, 0, 1'b0, 1'b1, 32'd0, "count0");
    expect_val(2, 32'h0, "irq_pre");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h1, "exp_set");
    expect_val(2, 32'h0, "irq_lag");
    cyc(A_CTRL, 0, 1'b0, 1'b1, 32'h4, "ctrl_en_clr");
    expect_val(2, 32'h1, "irq_set");
    cyc(A_CNT, 0, 1'b0, 1'b1, 32'h0, "count_hold");
    cyc(A_LOAD, 0, 1'b0, 1'b1, 32'd3, "load_rb");
    cyc(A_STAT, 32'h1, 1'b1, 1'b1, 32'h1, "status_pre_w1c");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h0, "status_w1c");
    expect_val(2, 32'h1, "irq_hold_after_w1c");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h0, "status_stays_clr");
    expect_val(2, 32'h0, "irq_clr");

    // auto-reload with LOAD=0 and W1C race
    cyc(A_LOAD, 32'd0, 1'b1, 1'b0, 0, "");
    cyc(A_CTRL, 32'h3, 1'b1, 1'b0, 0, "");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h0, "auto_first");
    cyc(A_STAT, 32'h1, 1'b1, 1'b1, 32'h1, "auto_exp");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h1, "w1c_race");
    cyc(A_STAT, 32'h1, 1'b1, 1'b1, 32'h1, "auto_again");
    cyc(A_CTRL, 32'h0, 1'b1, 1'b1, 32'h3, "ctrl_auto_rb");
    cyc(A_STAT, 32'h1, 1'b1, 1'b1, 32'h1, "status_before_clear");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h0, "idle_w1c");
    expect_val(2, 32'h0, "auto_irq_off");
    cyc(A_CTRL, 0, 1'b0, 1'b1, 32'h0, "ctrl_idle_rb");

    // start a long run, then reset at count 50
    cyc(A_LOAD, 32'd100, 1'b1, 1'b0, 0, "");
    cyc(A_CTRL, 32'h5, 1'b1, 1'b0, 0, "");
    cyc(A_CNT, 0, 1'b0, 1'b1, 32'd100, "run_count100");
    for (int i = 1; i < 50; i++) cyc(A_CNT, 0, 1'b0, 1'b1, 32'(100 - i), "run_count");
    cyc(A_CNT, 0, 1'b0, 1'b0, 0, "");
`else
    // timer registers absent
    cyc(A_LOAD, 32'd5, 1'b1, 1'b1, 32'h0, "load_off_wr");
    cyc(A_CTRL, 32'h5, 1'b1, 1'b1, 32'h0, "ctrl_off_wr");
    cyc(A_LOAD, 0, 1'b0, 1'b1, 32'h0, "load_off");
    cyc(A_CTRL, 0, 1'b0, 1'b1, 32'h0, "ctrl_off");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h0, "status_off");
    repeat (8) cyc(A_CNT, 0, 1'b0, 1'b1, 32'h0, "count_off");
    expect_val(2, 32'h0, "irq_off");
    cyc(A_CNT, 0, 1'b0, 1'b0, 0, "");
`endif

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    expect_val(0, 32'h0, "rst_count");
    expect_val(1, 32'h0, "rst_led_async");
    expect_val(2, 32'h0, "rst_irq_async");
    cyc(A_CTRL, 0, 1'b0, 1'b1, 32'h0, "rst_ctrl");
    cyc(A_LOAD, 0, 1'b0, 1'b1, 32'h0, "rst_load");
    cyc(A_STAT, 0, 1'b0, 1'b1, 32'h0, "rst_status");
    cyc(A_CYC, 0, 1'b0, 1'b1, 32'h0, "rst_cycle_mid");
    cyc(A_SW, 0, 1'b0, 1'b1, 32'h0, "rst_sw");
    @(posedge clk); #1 rst_n = 1'b1;
    led_ref = '0;
    cyc(32'h10, 0, 1'b0, 1'b1, ram_ref[4], "ram_kept");
    cyc(A_CNT, 0, 1'b0, 1'b1, 32'h0, "post_count");
    expect_val(1, 32'h0, "post_led");
    expect_val(2, 32'h0, "post_irq");
    cyc(A_CYC, 0, 1'b0, 1'b0, 0, "");
    expect_val(0, cyc_ref, "post_cycle");

    repeat (3) @(posedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
